// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Drives the single register-file write port from two result producers:
//   the ALU completion path and the load-return path. Each producer feeds a
//   small FIFO through a valid/ready handshake. Load data is aligned and
//   extended before it is queued. Every cycle one queue head is moved into
//   the output register. The load head normally wins, and a starvation
//   counter forces the ALU head through after STARVE_MAX lost cycles.
//
// Ports
//   i_clk           clock, rising edge active
//   i_reset         asynchronous reset, active low (asserted when 0)
//   i_alu_valid     ALU result offered
//   o_alu_ready     ALU queue can accept
//   i_alu_rd        ALU destination register
//   i_alu_data      ALU result value
//   i_ld_valid      load return offered
//   o_ld_ready      load queue can accept
//   i_ld_rd         load destination register
//   i_ld_raw        raw memory word
//   i_ld_funct3     load type (LB/LH/LW/LBU/LHU)
//   i_ld_addr_lo    byte address bits [1:0]
//   o_write_addr    register-file write address
//   o_write_data    register-file write data
//   o_write_enable  register-file write enable
//   o_busy_mask     bit r set while a write to r is queued or presented

// WbQueue
//   DEPTH-entry FIFO of {rd, data} for one producer. It reports its head,
//   its fill state, and a mask of every destination register it holds.
//
// Ports
//   i_clk, i_reset  clock and active-low async reset
//   i_push          enqueue i_rd/i_data this edge (caller guarantees not full)
//   i_rd, i_data    entry to enqueue
//   i_pop           dequeue the head this edge (caller guarantees not empty)
//   o_notFull       count < DEPTH
//   o_notEmpty      count != 0
//   o_headRd        head entry destination
//   o_headData      head entry value
//   o_pendMask      one bit per register targeted by a held entry
module WbQueue #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_push,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_data,
  input  logic        i_pop,
  output logic        o_notFull,
  output logic        o_notEmpty,
  output logic [4:0]  o_headRd,
  output logic [31:0] o_headData,
  output logic [31:0] o_pendMask
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  // Pointers and count. DEPTH is a power of two, so the pointers wrap
  // naturally. A push and a pop on the same edge leave the count unchanged.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The storage needs no reset. An entry only counts while it lies inside
  // the occupied window.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_rd[r_wrPtr]   <= i_rd;
      r_data[r_wrPtr] <= i_data;
    end
  end

  assign o_notFull  = (r_count < CW'(DEPTH));
  assign o_notEmpty = (r_count != '0);
  assign o_headRd   = r_rd[r_rdPtr];
  assign o_headData = r_data[r_rdPtr];

  // A slot is occupied when its distance from the read pointer is below
  // the count.
  always_comb begin
    logic [PW-1:0] offset;
    offset     = '0;
    o_pendMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - r_rdPtr;
      if ({1'b0, offset} < r_count) o_pendMask[r_rd[i]] = 1'b1;
    end
  end
endmodule

module regfile_writeback #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_alu_valid,
  output logic        o_alu_ready,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_raw,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  output logic [4:0]  o_write_addr,
  output logic [31:0] o_write_data,
  output logic        o_write_enable,
  output logic [31:0] o_busy_mask
);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic          w_aluNotFull, w_aluNotEmpty, w_ldNotFull, w_ldNotEmpty;
  logic [4:0]    w_aluHeadRd, w_ldHeadRd;
  logic [31:0]   w_aluHeadData, w_ldHeadData;
  logic [31:0]   w_aluPend, w_ldPend, w_outMask;
  logic          w_aluPush, w_ldPush, w_aluWins, w_ldWins;
  logic [7:0]    w_ldByte;
  logic [15:0]   w_ldHalf;
  logic [31:0]   w_ldData;
  logic [SW-1:0] r_starve;
  logic [4:0]    r_writeAddr;
  logic [31:0]   r_writeData;
  logic          r_writeEnable;

  // The readies are gated by reset, so nothing is accepted while reset is held.
  assign o_alu_ready = i_reset & w_aluNotFull;
  assign o_ld_ready  = i_reset & w_ldNotFull;

  // A handshake on rd 0 completes but is dropped, because x0 is never written.
  assign w_aluPush = i_alu_valid & o_alu_ready & (i_alu_rd != 5'd0);
  assign w_ldPush  = i_ld_valid  & o_ld_ready  & (i_ld_rd  != 5'd0);

  // Align the load word to the addressed byte or halfword, then extend it.
  always_comb begin
    w_ldByte = 8'(i_ld_raw >> {i_ld_addr_lo, 3'b000});
    w_ldHalf = i_ld_addr_lo[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
    case (i_ld_funct3)
      3'b000:  w_ldData = {{24{w_ldByte[7]}}, w_ldByte};
      3'b001:  w_ldData = {{16{w_ldHalf[15]}}, w_ldHalf};
      3'b100:  w_ldData = {24'd0, w_ldByte};
      3'b101:  w_ldData = {16'd0, w_ldHalf};
      default: w_ldData = i_ld_raw;
    endcase
  end

  WbQueue #(.DEPTH(DEPTH)) u_aluQueue (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_aluPush),
    .i_rd       (i_alu_rd),
    .i_data     (i_alu_data),
    .i_pop      (w_aluWins),
    .o_notFull  (w_aluNotFull),
    .o_notEmpty (w_aluNotEmpty),
    .o_headRd   (w_aluHeadRd),
    .o_headData (w_aluHeadData),
    .o_pendMask (w_aluPend)
  );

  WbQueue #(.DEPTH(DEPTH)) u_ldQueue (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_ldPush),
    .i_rd       (i_ld_rd),
    .i_data     (w_ldData),
    .i_pop      (w_ldWins),
    .o_notFull  (w_ldNotFull),
    .o_notEmpty (w_ldNotEmpty),
    .o_headRd   (w_ldHeadRd),
    .o_headData (w_ldHeadData),
    .o_pendMask (w_ldPend)
  );

  // The load head has priority. The ALU head wins when it is alone or when it
  // has lost STARVE_MAX cycles in a row.
  assign w_aluWins = w_aluNotEmpty & (~w_ldNotEmpty | (r_starve == SW'(STARVE_MAX)));
  assign w_ldWins  = w_ldNotEmpty & ~w_aluWins;

  // The starvation counter only runs while an ALU entry is waiting behind a load.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_starve <= '0;
    end else if (!w_aluNotEmpty || w_aluWins) begin
      r_starve <= '0;
    end else if (w_ldWins) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // The output register presents the winner. On idle cycles the address and
  // data hold their last values, and only the enable drops.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_writeAddr   <= '0;
      r_writeData   <= '0;
      r_writeEnable <= 1'b0;
    end else if (w_aluWins) begin
      r_writeAddr   <= w_aluHeadRd;
      r_writeData   <= w_aluHeadData;
      r_writeEnable <= 1'b1;
    end else if (w_ldWins) begin
      r_writeAddr   <= w_ldHeadRd;
      r_writeData   <= w_ldHeadData;
      r_writeEnable <= 1'b1;
    end else begin
      r_writeEnable <= 1'b0;
    end
  end

  // The presented write stays busy until its commit edge has passed.
  always_comb begin
    w_outMask = '0;
    if (r_writeEnable) w_outMask[r_writeAddr] = 1'b1;
  end

  assign o_busy_mask    = (w_aluPend | w_ldPend | w_outMask) & ~32'h1;
  assign o_write_addr   = r_writeAddr;
  assign o_write_data   = r_writeData;
  assign o_write_enable = r_writeEnable;
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer for the register-file write port (write_addr / write_data / write_enable).
- Merges two result producers into the single write port: the ALU/execute completion path and the load-return path from memory.
- Each producer has a 2-entry queue with a valid/ready handshake. Load data is aligned and sign- or zero-extended before it is queued.
- Exports busy_mask so decode/hazard logic can stall on pending writes.

Parameters:
- DEPTH, 2, entries per source queue (power of two, at least 2).
- STARVE_MAX, 4, consecutive cycles the ALU head may lose arbitration before it is forced to win.

Ports:
- clk  input  1  clock, rising edge active
- reset  input  1  asynchronous active-low reset; asserted when 0
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU queue can accept
- alu_rd  input  5  destination register
- alu_data  input  32  result value
- ld_valid  input  1  load return offered
- ld_ready  output  1  load queue can accept
- ld_rd  input  5  destination register
- ld_raw  input  32  raw memory word
- ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_addr_lo  input  2  byte address bits [1:0]
- write_addr  output  5  to register file
- write_data  output  32  to register file
- write_enable  output  1  to register file
- busy_mask  output  32  bit r = 1 while a write to register r is queued or presented

Behaviour:
- **Reset:** reset = 0 clears both queues, the starvation counter and the output register.
  - write_enable = 0, write_addr = 0, write_data = 0, busy_mask = 0.
  - alu_ready = 0 and ld_ready = 0 while reset is 0.
- **Handshake:** transfer happens at a rising edge when valid & ready.
  - ready = (queue count < DEPTH). ready does not depend on a same-cycle dequeue, so a full queue never accepts.
  - Producers hold their inputs stable until the transfer.
- **rd = 0:** the transfer completes normally but the entry is discarded, never enqueued. busy_mask[0] is constantly 0.
- **Load alignment** (combinational, applied before enqueue):
  - LB/LBU select byte ld_addr_lo; LH/LHU select halfword ld_addr_lo[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW, and any other funct3, passes ld_raw unchanged.
- **Arbitration** (every cycle, over the queue heads):
  - Default: the load head wins over the ALU head.
  - A counter increments each cycle the ALU queue is non-empty and the load head wins.
  - When the counter equals STARVE_MAX, the ALU head wins and the counter clears.
  - The counter also clears whenever the ALU head wins or the ALU queue is empty.
  - Exactly one head is dequeued per cycle when either queue is non-empty.
- **Output register:**
  - At each edge, the winning head loads write_addr/write_data with write_enable = 1.
  - If both queues are empty, write_enable = 0 and addr/data hold their last values.
- **Latency:** an entry accepted at edge N appears on the write port no earlier than edge N+1. The register file commits it at edge N+2.
  - Full throughput: 1 write per cycle total.
- **Simultaneous enqueue and dequeue** on the same queue in one edge: count is unchanged and order is preserved (FIFO).
- **busy_mask:**
  - Bit r is set from the accept edge.
  - It stays set while any queued entry targets r, or while the output register presents r with write_enable = 1.
  - It clears after the register-file commit edge.
  - If entries to the same r exist in both queues, the bit stays set until the last of them has committed.
- **Same-register ordering:** a given rd written by both sources is committed in arbitration order. Producers are responsible for ordering; this block does not reorder within a source.
- **Reset mid-operation:** all queued and presented writes are dropped. No partial write is emitted after reset releases.

Test Plan:
- Reset held low with both valid = 1 → alu_ready = ld_ready = 0, write_enable = 0, busy_mask = 0. After release both readies = 1.
- ALU rd = 1, data 0x12345678 accepted at edge N → write_enable = 1, write_addr = 1, write_data = 0x12345678 after edge N+1. busy_mask[1] = 1 from edge N until after edge N+2.
- Load ld_raw 0x80FF7F01, LB with addr_lo 3 → 0xFFFFFF80. LBU addr_lo 0 → 0x00000001. LH addr_lo 2 → 0xFFFF80FF. LHU addr_lo 0 → 0x00007F01. LW → 0x80FF7F01.
- ALU rd = 0, data 0xDEADBEEF → handshake completes, write_enable never asserts, busy_mask stays 0.
- Both sources continuously valid, STARVE_MAX = 4 → write-port source sequence L,L,L,L,A repeating. Neither ready drops below the queue-full rule. Per-source order preserved.
- Fill the ALU queue to DEPTH while loads win → alu_ready = 0, and stays 0 in the cycle of an ALU dequeue. Assert reset mid-stream → all pending writes lost, busy_mask = 0.
